// File: rtl/operand_stream_feeder_pkg.sv
// Shared types and constants for the operand stream feeder.
package feeder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} feeder_state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/operand_stream_feeder_if.sv
// Operand handshake between the feeder (master) and the convolution controller (slave).
interface operand_stream_feeder_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  write_af;
  logic                  write_as;
  logic                  write_bf;
  logic                  write_bs;
  logic                  ready;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  write_af, write_as, write_bf, write_bs, ready,
    output valid, data_out
  );

  modport slave (
    output write_af, write_as, write_bf, write_bs, ready,
    input  valid, data_out
  );

endinterface

// File: rtl/operand_stream_feeder_fifo.sv
// Two-entry register FIFO used as the per-stream prefetch buffer.
module prefetch_fifo2
  import feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count_q == '0) head_d = din_i;
          else               tail_d = din_i;
          count_d = count_q + 1'b1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 1'b1;
        end
        // Simultaneous push/pop only occurs with one entry: the new word becomes head.
        2'b11: head_d = din_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/operand_stream_feeder.sv
// Streams activation and weight words from two operand SRAMs to the controller handshake.
module operand_stream_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned A_BEATS    = 4096,
  parameter int unsigned W_BEATS    = 1024
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  output logic                  act_mem_re,
  output logic [ADDR_WIDTH-1:0] act_mem_addr,
  input  logic [DATA_WIDTH-1:0] act_mem_rdata,
  output logic                  w_mem_re,
  output logic [ADDR_WIDTH-1:0] w_mem_addr,
  input  logic [DATA_WIDTH-1:0] w_mem_rdata,
  output logic                  protocol_err,
  operand_stream_feeder_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] A_TOTAL = ADDR_WIDTH'(A_BEATS);
  localparam logic [ADDR_WIDTH-1:0] W_TOTAL = ADDR_WIDTH'(W_BEATS);
  localparam int unsigned           OCC_W   = FIFO_CNT_W + 1;

  feeder_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_cnt_q, a_cnt_d, w_cnt_q, w_cnt_d;
  logic                  a_infl_q, w_infl_q, err_q;
  logic                  fifo_clear, a_pop, w_pop, a_empty, w_empty;
  logic [FIFO_CNT_W-1:0] a_count, w_count;
  logic [DATA_WIDTH-1:0] a_head, w_head, data_sel;
  logic                  sel_a, sel_w, valid_sel;
  logic                  a_left, w_left, a_room, w_room;

  assign sel_a  = bus.write_af | bus.write_as;
  assign sel_w  = bus.write_bf | bus.write_bs;
  assign a_left = (a_cnt_q < A_TOTAL);
  assign w_left = (w_cnt_q < W_TOTAL);
  // Words in flight count against FIFO space so a returning read always has a slot.
  assign a_room = (OCC_W'(a_count) + OCC_W'(a_infl_q)) < OCC_W'(FIFO_DEPTH);
  assign w_room = (OCC_W'(w_count) + OCC_W'(w_infl_q)) < OCC_W'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    a_cnt_d    = a_cnt_q;
    w_cnt_d    = w_cnt_q;
    fifo_clear = 1'b0;
    act_mem_re = 1'b0;
    w_mem_re   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          a_cnt_d    = '0;
          w_cnt_d    = '0;
          fifo_clear = 1'b1;
        end
      end
      RUN: begin
        act_mem_re = a_left && a_room;
        w_mem_re   = w_left && w_room;
        if (act_mem_re) a_cnt_d = a_cnt_q + 1'b1;
        if (w_mem_re)   w_cnt_d = w_cnt_q + 1'b1;
        if (!a_left && !w_left) state_d = DRAIN;
      end
      DRAIN: begin
        if (a_empty && w_empty && !a_infl_q && !w_infl_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q  <= IDLE;
      a_cnt_q  <= '0;
      w_cnt_q  <= '0;
      a_infl_q <= 1'b0;
      w_infl_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_cnt_q  <= a_cnt_d;
      w_cnt_q  <= w_cnt_d;
      a_infl_q <= act_mem_re;
      w_infl_q <= w_mem_re;
      if (sel_a && sel_w) err_q <= 1'b1;
    end
  end

  // Weight wins when both streams are requested.
  always_comb begin
    valid_sel = 1'b0;
    data_sel  = '0;
    a_pop     = 1'b0;
    w_pop     = 1'b0;
    if (sel_w) begin
      valid_sel = !w_empty;
      data_sel  = w_head;
      w_pop     = !w_empty && bus.ready;
    end else if (sel_a) begin
      valid_sel = !a_empty;
      data_sel  = a_head;
      a_pop     = !a_empty && bus.ready;
    end
  end

  prefetch_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_act_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear_i   (fifo_clear),
    .push_i    (a_infl_q),
    .pop_i     (a_pop),
    .din_i     (act_mem_rdata),
    .empty_o   (a_empty),
    .count_o   (a_count),
    .head_o    (a_head)
  );

  prefetch_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_w_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear_i   (fifo_clear),
    .push_i    (w_infl_q),
    .pop_i     (w_pop),
    .din_i     (w_mem_rdata),
    .empty_o   (w_empty),
    .count_o   (w_count),
    .head_o    (w_head)
  );

  assign bus.valid    = valid_sel;
  assign bus.data_out = data_sel;
  assign act_mem_addr = a_cnt_q;
  assign w_mem_addr   = w_cnt_q;
  assign running      = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign protocol_err = err_q;

endmodule
